bias_sched: RTL and testbench

Sequencing controller for the bias adder stage of the accelerator datapath. It holds a per-output-channel bias table loaded at configuration time. For each accepted accumulated-kernel beat, it drives the adder enable and the bias for the current channel, then walks pixel and channel counters across one layer. It provides valid/ready flow control on both sides of the adder, a channel tag aligned with each adder result, and a done pulse at end of layer.

---
 rtl/bias_sched_pkg.sv | 25 ++
 rtl/bias_sched_if.sv | 31 +++
 rtl/bias_sched_table.sv | 34 +++
 rtl/bias_sched.sv | 141 ++++++++++++++
 tb/tb_bias_sched.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/bias_sched_pkg.sv
// bias_sched_pkg: shared types and default widths for the bias adder
// sequencer and the adder datapath around it.
//   state_t : scheduler FSM states
//   ch_w()  : channel-index width for a given bias table depth
//   B_BW, AK_BW, NUM_CH, PX_W : default widths / depths
package bias_sched_pkg;

  localparam int B_BW   = 8;
  localparam int AK_BW  = 20;
  localparam int NUM_CH = 16;
  localparam int PX_W   = 16;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W = ch_w(NUM_CH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bias_sched_if.sv
// bias_sched_if: beat handshake on both sides of the bias adder.
//   i_acc_valid / o_acc_ready : upstream accumulated-kernel beat
//   o_en, o_bias              : adder enable and bias for the current channel
//   o_out_valid / i_out_ready : downstream adder result, o_out_ch its tag
// master = datapath side driving the inputs, slave = bias_sched.
interface bias_sched_if
  import bias_sched_pkg::*;
#(
  parameter int B_BW = bias_sched_pkg::B_BW,
  parameter int CH_W = bias_sched_pkg::ch_w(bias_sched_pkg::NUM_CH)
) ();

  logic            i_acc_valid;
  logic            o_acc_ready;
  logic            o_en;
  logic [B_BW-1:0] o_bias;
  logic            i_out_ready;
  logic            o_out_valid;
  logic [CH_W-1:0] o_out_ch;

  modport master (
    output i_acc_valid, i_out_ready,
    input  o_acc_ready, o_en, o_bias, o_out_valid, o_out_ch
  );

  modport slave (
    input  i_acc_valid, i_out_ready,
    output o_acc_ready, o_en, o_bias, o_out_valid, o_out_ch
  );

endinterface

// File: rtl/bias_sched_table.sv
// bias_table: NUM_CH x B_BW bias register file, one synchronous write port
// and one asynchronous read port. Synchronous active-high rst clears it.
//   clk, rst      : clock, reset
//   we/waddr/wdata: write port
//   raddr/rdata   : combinational read port
module bias_table
  import bias_sched_pkg::*;
#(
  parameter int NUM_CH = bias_sched_pkg::NUM_CH,
  parameter int B_BW   = bias_sched_pkg::B_BW,
  parameter int CH_W   = bias_sched_pkg::ch_w(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [CH_W-1:0] waddr,
  input  logic [B_BW-1:0] wdata,
  input  logic [CH_W-1:0] raddr,
  output logic [B_BW-1:0] rdata
);

  logic [B_BW-1:0] mem [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bias_sched.sv
// bias_sched: sequences the bias adder across one layer. Walks pixel and
// channel counters per accepted beat, presents the channel bias to the adder,
// tags each result with its channel and pulses o_done at layer end.
//   clk, rst                      : clock, synchronous active-high reset
//   i_cfg_we/i_cfg_addr/i_cfg_bias: bias table write (IDLE only)
//   i_start, i_num_ch, i_num_px   : layer start and size (IDLE only)
//   dp (bias_sched_if.slave)      : adder-side handshake
//   o_busy, o_done                : status
//   o_stall_cnt                   : present only with BIAS_SCHED_STALL_CNT_EN
//
// state | meaning
// IDLE  | table writable, waiting for a valid start
// RUN   | accepting beats, walking px/ch counters
// DRAIN | last beat taken, waiting for its result to leave
module bias_sched
  import bias_sched_pkg::*;
#(
  parameter int NUM_CH = bias_sched_pkg::NUM_CH,
  parameter int B_BW   = bias_sched_pkg::B_BW,
  parameter int PX_W   = bias_sched_pkg::PX_W,
  parameter int CH_W   = bias_sched_pkg::ch_w(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_cfg_we,
  input  logic [CH_W-1:0] i_cfg_addr,
  input  logic [B_BW-1:0] i_cfg_bias,
  input  logic            i_start,
  input  logic [CH_W:0]   i_num_ch,
  input  logic [PX_W-1:0] i_num_px,
  bias_sched_if.slave     dp,
  output logic            o_busy,
  output logic            o_done
`ifdef BIAS_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]     o_stall_cnt
`endif
);

  state_t          state;
  logic [PX_W-1:0] px_cnt;
  logic [PX_W-1:0] num_px_q;
  logic [CH_W-1:0] ch_cnt;
  logic [CH_W:0]   num_ch_q;
  logic            start_ok;
  logic            last_px;
  logic            last_ch;
  logic            drain_ok;

  assign start_ok = (state == RUN) ? 1'b0 :
                    (state == IDLE) && i_start && (i_num_ch != '0) &&
                    (i_num_ch <= (CH_W+1)'(NUM_CH)) && (i_num_px != '0);

  assign dp.o_acc_ready = (state == RUN) && (!dp.o_out_valid || dp.i_out_ready);
  assign dp.o_en        = dp.i_acc_valid && dp.o_acc_ready;

  assign last_px  = (px_cnt == num_px_q - 1'b1);
  assign last_ch  = ({1'b0, ch_cnt} == num_ch_q - 1'b1);
  assign drain_ok = !dp.o_out_valid || dp.i_out_ready;

  // Done is Mealy so it lands in the same cycle the final result leaves;
  // busy falls at the edge that closes that cycle.
  assign o_done = (state == DRAIN) && drain_ok;
  assign o_busy = (state != IDLE);

  bias_table #(
    .NUM_CH (NUM_CH),
    .B_BW   (B_BW),
    .CH_W   (CH_W)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    ((state == IDLE) && i_cfg_we),
    .waddr (i_cfg_addr),
    .wdata (i_cfg_bias),
    .raddr (ch_cnt),
    .rdata (dp.o_bias)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      px_cnt         <= '0;
      ch_cnt         <= '0;
      num_px_q       <= '0;
      num_ch_q       <= '0;
      dp.o_out_valid <= 1'b0;
      dp.o_out_ch    <= '0;
    end else begin
      if (dp.o_en) begin
        dp.o_out_valid <= 1'b1;
        dp.o_out_ch    <= ch_cnt;
      end else if (dp.i_out_ready) begin
        dp.o_out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_ok) begin
            num_ch_q <= i_num_ch;
            num_px_q <= i_num_px;
            px_cnt   <= '0;
            ch_cnt   <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (dp.o_en) begin
            if (last_px) begin
              px_cnt <= '0;
              // ch_cnt parks on the last channel until the layer closes
              if (last_ch) state <= DRAIN;
              else         ch_cnt <= ch_cnt + 1'b1;
            end else begin
              px_cnt <= px_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_ok) begin
            ch_cnt <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BIAS_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      o_stall_cnt <= '0;
    end else if ((state == RUN) && dp.i_acc_valid && !dp.o_acc_ready &&
                 (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bias_sched.sv
module tb_bias_sched;
  import bias_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_cfg_we;
  logic [3:0] i_cfg_addr;
  logic [7:0] i_cfg_bias;
  logic       i_start;
  logic [4:0] i_num_ch;
  logic [15:0] i_num_px;
  logic       o_busy;
  logic       o_done;
`ifdef BIAS_SCHED_STALL_CNT_EN
  logic [31:0] o_stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  bias_sched_if #(.B_BW(8), .CH_W(4)) dp ();

  bias_sched #(.NUM_CH(16), .B_BW(8), .PX_W(16), .CH_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_cfg_we   (i_cfg_we),
    .i_cfg_addr (i_cfg_addr),
    .i_cfg_bias (i_cfg_bias),
    .i_start    (i_start),
    .i_num_ch   (i_num_ch),
    .i_num_px   (i_num_px),
    .dp         (dp),
    .o_busy     (o_busy),
    .o_done     (o_done)
`ifdef BIAS_SCHED_STALL_CNT_EN
    ,
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    i_cfg_we = 1'b1; i_cfg_addr = a; i_cfg_bias = d;
    tick();
    i_cfg_we = 1'b0;
  endtask

  task automatic start(input logic [4:0] nch, input logic [15:0] npx);
    i_start = 1'b1; i_num_ch = nch; i_num_px = npx;
    tick();
    i_start = 1'b0;
  endtask

  // Per-cycle expected patterns, bit/nibble c belongs to cycle c after start.
  task automatic run_layer(input string tag, input int ncyc,
                           input logic [19:0] rdy, input logic [19:0] en_p,
                           input logic [19:0] vld_p, input logic [19:0] dn_p,
                           input logic [79:0] ch_p, input logic [79:0] bs_p);
    logic done_seen;
    done_seen = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      dp.i_out_ready = rdy[c];
      @(negedge clk);
      chk($sformatf("%s_en_c%0d", tag, c), dp.o_en, en_p[c]);
      chk($sformatf("%s_ardy_c%0d", tag, c), dp.o_acc_ready, en_p[c]);
      chk($sformatf("%s_vld_c%0d", tag, c), dp.o_out_valid, vld_p[c]);
      chk($sformatf("%s_done_c%0d", tag, c), o_done, dn_p[c]);
      chk($sformatf("%s_busy_c%0d", tag, c), o_busy, !done_seen);
      if (vld_p[c]) chk($sformatf("%s_ch_c%0d", tag, c), dp.o_out_ch, ch_p[c*4 +: 4]);
      if (en_p[c])  chk($sformatf("%s_bias_c%0d", tag, c), dp.o_bias, bs_p[c*4 +: 4]);
      if (dn_p[c]) done_seen = 1'b1;
      tick();
    end
  endtask

  initial begin
    logic seen;
    rst = 1'b1; i_cfg_we = 0; i_cfg_addr = 0; i_cfg_bias = 0;
    i_start = 0; i_num_ch = 0; i_num_px = 0;
    dp.i_acc_valid = 0; dp.i_out_ready = 1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_vld", dp.o_out_valid, 0);
    chk("rst_ardy", dp.o_acc_ready, 0);
    chk("rst_en", dp.o_en, 0);
    chk("rst_done", o_done, 0);
    chk("rst_bias", dp.o_bias, 0);
    chk("rst_ch", dp.o_out_ch, 0);
    tick();

    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    @(negedge clk);
    chk("load_bias0", dp.o_bias, 1);
    tick();

    // Full-throughput layer, 4 ch x 2 px
    dp.i_acc_valid = 1;
    start(4, 2);
    run_layer("full", 10, 20'hFFFFF, 20'h000FF, 20'h001FE, 20'h00100,
              80'h332211000, 80'h44332211);

    // Backpressure for 3 cycles after beat 2
    start(4, 2);
    run_layer("bp", 13, 20'hFFFE3, 20'h007E3, 20'h00FFE, 20'h00800,
              80'h332211000000, 80'h44332200011);

    // Rejected starts
    dp.i_acc_valid = 0;
    start(0, 2);
    @(negedge clk); chk("nch0_busy", o_busy, 0); tick();
    start(17, 2);
    @(negedge clk); chk("nch17_busy", o_busy, 0); tick();
    start(4, 0);
    @(negedge clk); chk("npx0_busy", o_busy, 0); chk("npx0_ardy", dp.o_acc_ready, 0); tick();

    // Config write during RUN is dropped
    start(1, 2);
    wr(0, 8'h99);
    @(negedge clk);
    chk("cfgrun_busy", o_busy, 1);
    chk("cfgrun_bias", dp.o_bias, 1);
    tick();
    dp.i_acc_valid = 1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
      tick();
    end
    chk("cfgrun_done_seen", seen, 1);
    dp.i_acc_valid = 0;
    @(negedge clk);
    chk("cfgrun_idle", o_busy, 0);
    chk("cfgrun_table0", dp.o_bias, 1);
    tick();

    // 16 ch x 1 px, table[0] written in the same cycle as start
    for (int i = 1; i < 16; i++) wr(4'(i), 8'(i + 1));
    dp.i_acc_valid = 1;
    i_cfg_we = 1; i_cfg_addr = 0; i_cfg_bias = 8'h20;
    start(16, 1);
    i_cfg_we = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c < 16) begin
        chk($sformatf("wide_en_c%0d", c), dp.o_en, 1);
        chk($sformatf("wide_bias_c%0d", c), dp.o_bias, (c == 0) ? 32'h20 : 32'(c + 1));
      end
      if (c >= 1 && c <= 16) chk($sformatf("wide_ch_c%0d", c), dp.o_out_ch, 32'(c - 1));
      if (c == 16) begin
        chk("wide_done", o_done, 1);
        chk("wide_ardy", dp.o_acc_ready, 0);
      end
      if (c == 17) begin
        chk("wide_busy", o_busy, 0);
        chk("wide_vld", dp.o_out_valid, 0);
        chk("wide_done_off", o_done, 0);
      end
      tick();
    end

    // Reset mid-RUN after 3 beats
    start(4, 2);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstrun_busy", o_busy, 0);
    chk("rstrun_vld", dp.o_out_valid, 0);
    chk("rstrun_bias", dp.o_bias, 0);
    chk("rstrun_ardy", dp.o_acc_ready, 0);
    tick();
    start(1, 1);
    @(negedge clk);
    chk("rstrun_restart_en", dp.o_en, 1);
    chk("rstrun_restart_bias", dp.o_bias, 0);
    tick();
    @(negedge clk);
    chk("rstrun_restart_done", o_done, 1);
    tick();

`ifdef BIAS_SCHED_STALL_CNT_EN
    // 5 stall cycles: result held with i_out_ready low while valid is up
    start(1, 8);
    @(negedge clk); chk("stall_c0", o_stall_cnt, 0); tick();
    dp.i_out_ready = 0;
    repeat (5) tick();
    dp.i_out_ready = 1;
    @(negedge clk);
    chk("stall_cnt5", o_stall_cnt, 5);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
      tick();
    end
    chk("stall_done_seen", seen, 1);
    chk("stall_hold", o_stall_cnt, 5);
    start(1, 1);
    @(negedge clk);
    chk("stall_clear", o_stall_cnt, 0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
